// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cache pipeline among NUM_PE requesters.
// Optional performance counters are enabled with CACHE_ARB_PERF_EN.
module cache_port_arbiter #(
   parameter int unsigned NUM_PE     = 4,
   parameter int unsigned ID_WIDTH   = 2,
   parameter int unsigned ADDR_WIDTH = 33,
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned PIPE_DEPTH = 3
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_PE-1:0]                     req_valid_i,
   input  logic [NUM_PE-1:0][ADDR_WIDTH-1:0]     req_addr_i,
   input  logic [NUM_PE-1:0][DATA_WIDTH-1:0]     req_wdata_i,
   output logic [NUM_PE-1:0]                     req_ready_o,
   output logic                                  cache_valid_o,
   output logic [ADDR_WIDTH-1:0]                 cache_addr_o,
   output logic [DATA_WIDTH-1:0]                 cache_wdata_o,
   input  logic                                  cache_stall_i,
   input  logic                                  cache_resp_hit_i,
   input  logic [DATA_WIDTH-1:0]                 cache_resp_data_i,
   output logic [NUM_PE-1:0]                     resp_valid_o,
   output logic                                  resp_hit_o,
   output logic [DATA_WIDTH-1:0]                 resp_data_o
`ifdef CACHE_ARB_PERF_EN
   ,
   output logic [31:0]                           perf_grants_o,
   output logic [31:0]                           perf_stall_cycles_o,
   output logic [31:0]                           perf_misses_o
`endif
);

   typedef enum logic [0:0] {StArb, StStall} state_e;

   state_e                             state_q;
   logic [ID_WIDTH-1:0]                rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]                cand;
   logic [ID_WIDTH-1:0]                gnt_id;
   logic                               gnt_found;
   logic                               grant;
   logic                               cache_valid_q;
   logic [ADDR_WIDTH-1:0]              cache_addr_q;
   logic [DATA_WIDTH-1:0]              cache_wdata_q;
   logic [PIPE_DEPTH-1:0]              tag_vld_q;
   logic [PIPE_DEPTH-1:0][ID_WIDTH-1:0] tag_id_q;
   logic [PIPE_DEPTH-1:0]              tag_rw_q;
   logic [NUM_PE-1:0]                  resp_valid_q;
   logic                               resp_hit_q;
   logic [DATA_WIDTH-1:0]              resp_data_q;
   logic                               final_vld;
   logic                               final_rw;
   logic [ID_WIDTH-1:0]                final_id;

   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         cand = rr_ptr_q + ID_WIDTH'(i);
         if (!gnt_found && req_valid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   // A stalled cycle never grants, whichever state the FSM is in.
   assign grant       = gnt_found && !cache_stall_i && !rst_i;
   assign req_ready_o = grant ? (NUM_PE'(1) << gnt_id) : '0;
   assign rr_ptr_d    = gnt_id + ID_WIDTH'(1);

   assign final_vld = tag_vld_q[PIPE_DEPTH-1];
   assign final_rw  = tag_rw_q[PIPE_DEPTH-1];
   assign final_id  = tag_id_q[PIPE_DEPTH-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StArb;
         rr_ptr_q      <= '0;
         cache_valid_q <= 1'b0;
         cache_addr_q  <= '0;
         cache_wdata_q <= '0;
         tag_vld_q     <= '0;
         tag_id_q      <= '0;
         tag_rw_q      <= '0;
         resp_valid_q  <= '0;
         resp_hit_q    <= 1'b0;
         resp_data_q   <= '0;
      end else begin
         case (state_q)
            StArb:   if (cache_stall_i)  state_q <= StStall;
            StStall: if (!cache_stall_i) state_q <= StArb;
            default: state_q <= StArb;
         endcase

         if (!cache_stall_i) begin
            cache_valid_q <= grant;
            if (grant) begin
               cache_addr_q  <= req_addr_i[gnt_id];
               cache_wdata_q <= req_wdata_i[gnt_id];
               rr_ptr_q      <= rr_ptr_d;
            end
            tag_vld_q[0] <= grant;
            tag_id_q[0]  <= gnt_id;
            tag_rw_q[0]  <= req_addr_i[gnt_id][ADDR_WIDTH-1];
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
               tag_vld_q[k] <= tag_vld_q[k-1];
               tag_id_q[k]  <= tag_id_q[k-1];
               tag_rw_q[k]  <= tag_rw_q[k-1];
            end
            resp_valid_q <= final_vld ? (NUM_PE'(1) << final_id) : '0;
            resp_hit_q   <= final_vld && cache_resp_hit_i;
            resp_data_q  <= (final_vld && final_rw && cache_resp_hit_i) ? cache_resp_data_i : '0;
         end else begin
            // Pipeline frozen; a pending response is re-presented once the stall clears.
            resp_valid_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
         end
      end
   end

   assign cache_valid_o = cache_valid_q;
   assign cache_addr_o  = cache_addr_q;
   assign cache_wdata_o = cache_wdata_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_hit_o    = resp_hit_q;
   assign resp_data_o   = resp_data_q;

`ifdef CACHE_ARB_PERF_EN
   logic [31:0] perf_grants_q, perf_stall_q, perf_miss_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_grants_q <= '0;
         perf_stall_q  <= '0;
         perf_miss_q   <= '0;
      end else begin
         if (grant && perf_grants_q != '1) perf_grants_q <= perf_grants_q + 32'd1;
         if (cache_stall_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
         if (!cache_stall_i && final_vld && !cache_resp_hit_i && perf_miss_q != '1) begin
            perf_miss_q <= perf_miss_q + 32'd1;
         end
      end
   end

   assign perf_grants_o       = perf_grants_q;
   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_misses_o       = perf_miss_q;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model of grants and in-flight requests.
module tb_cache_port_arbiter;
   localparam int NP = 4;
   localparam int IW = 2;
   localparam int AW = 33;
   localparam int DW = 512;
   localparam int PD = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NP-1:0]           req_valid = '0;
   logic [NP-1:0][AW-1:0]   req_addr = '0;
   logic [NP-1:0][DW-1:0]   req_wdata = '0;
   logic [NP-1:0]           req_ready;
   logic                    cache_valid;
   logic [AW-1:0]           cache_addr;
   logic [DW-1:0]           cache_wdata;
   logic                    cache_stall = 1'b0;
   logic                    cache_resp_hit = 1'b0;
   logic [DW-1:0]           cache_resp_data = '0;
   logic [NP-1:0]           resp_valid;
   logic                    resp_hit;
   logic [DW-1:0]           resp_data;
`ifdef CACHE_ARB_PERF_EN
   logic [31:0]             perf_grants, perf_stall_cycles, perf_misses;
   int unsigned             m_grants, m_stalls, m_misses;
`endif

   cache_port_arbiter #(
      .NUM_PE(NP), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE_DEPTH(PD)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_valid_i       (req_valid),
      .req_addr_i        (req_addr),
      .req_wdata_i       (req_wdata),
      .req_ready_o       (req_ready),
      .cache_valid_o     (cache_valid),
      .cache_addr_o      (cache_addr),
      .cache_wdata_o     (cache_wdata),
      .cache_stall_i     (cache_stall),
      .cache_resp_hit_i  (cache_resp_hit),
      .cache_resp_data_i (cache_resp_data),
      .resp_valid_o      (resp_valid),
      .resp_hit_o        (resp_hit),
      .resp_data_o       (resp_data)
`ifdef CACHE_ARB_PERF_EN
      ,
      .perf_grants_o       (perf_grants),
      .perf_stall_cycles_o (perf_stall_cycles),
      .perf_misses_o       (perf_misses)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Each accepted request waits PD unstalled cycles after its grant cycle, then responds.
   typedef struct {
      int   id;
      logic rw;
      int   age;
   } flight_t;
   flight_t       inflight[$];
   int            ptr;
   logic          exp_cv;
   logic [AW-1:0] exp_ca;
   logic [DW-1:0] exp_cw;
   logic [NP-1:0] exp_rv;
   logic          exp_rh;
   logic [DW-1:0] exp_rd;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      inflight.delete();
      ptr    = 0;
      exp_cv = 1'b0;
      exp_ca = '0;
      exp_cw = '0;
      exp_rv = '0;
      exp_rh = 1'b0;
      exp_rd = '0;
`ifdef CACHE_ARB_PERF_EN
      m_grants = 0;
      m_stalls = 0;
      m_misses = 0;
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, DW'(req_ready), '0);
      chk({tag, "_cache_valid"}, DW'(cache_valid), '0);
      chk({tag, "_cache_addr"}, DW'(cache_addr), '0);
      chk({tag, "_cache_wdata"}, cache_wdata, '0);
      chk({tag, "_resp_valid"}, DW'(resp_valid), '0);
      chk({tag, "_resp_hit"}, DW'(resp_hit), '0);
      chk({tag, "_resp_data"}, resp_data, '0);
   endtask

   // One clock: check at the falling edge, advance the model across the rising edge.
   task automatic cycle();
      logic          found;
      int            g;
      int            idx;
      logic          n_cv, n_rh;
      logic [AW-1:0] n_ca;
      logic [DW-1:0] n_cw, n_rd;
      logic [NP-1:0] n_rv;
      @(negedge clk);
      chk("cache_valid", DW'(cache_valid), DW'(exp_cv));
      if (exp_cv) begin
         chk("cache_addr", DW'(cache_addr), DW'(exp_ca));
         chk("cache_wdata", cache_wdata, exp_cw);
      end
      chk("resp_valid", DW'(resp_valid), DW'(exp_rv));
      chk("resp_hit", DW'(resp_hit), DW'(exp_rh));
      chk("resp_data", resp_data, exp_rd);

      found = 1'b0;
      g     = 0;
      if (!cache_stall) begin
         for (int i = 0; i < NP; i++) begin
            idx = (ptr + i) % NP;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               g     = idx;
            end
         end
      end
      chk("req_ready", DW'(req_ready), found ? DW'(1) << g : '0);

      n_cv = exp_cv;
      n_ca = exp_ca;
      n_cw = exp_cw;
      n_rv = '0;
      n_rh = 1'b0;
      n_rd = '0;
      if (!cache_stall) begin
         if (inflight.size() > 0 && inflight[0].age == PD) begin
            n_rv = NP'(1) << inflight[0].id;
            n_rh = cache_resp_hit;
            n_rd = (inflight[0].rw && cache_resp_hit) ? cache_resp_data : '0;
`ifdef CACHE_ARB_PERF_EN
            if (!cache_resp_hit) m_misses++;
`endif
            void'(inflight.pop_front());
         end
         foreach (inflight[k]) inflight[k].age++;
         n_cv = found;
         if (found) begin
            inflight.push_back('{id: g, rw: req_addr[g][AW-1], age: 1});
            n_ca = req_addr[g];
            n_cw = req_wdata[g];
            ptr  = (g + 1) % NP;
`ifdef CACHE_ARB_PERF_EN
            m_grants++;
`endif
         end
      end
`ifdef CACHE_ARB_PERF_EN
      else m_stalls++;
`endif
      @(posedge clk);
      exp_cv = n_cv;
      exp_ca = n_ca;
      exp_cw = n_cw;
      exp_rv = n_rv;
      exp_rh = n_rh;
      exp_rd = n_rd;
      #1;
   endtask

   task automatic rand_reqs();
      for (int p = 0; p < NP; p++) begin
         req_addr[p]  = {1'($urandom), $urandom};
         req_wdata[p] = rand_data();
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("in_reset");
      rst = 1'b0;

      // All four PEs valid from reset: 0,1,2,3,0,... with in-order responses.
      rand_reqs();
      req_valid = 4'hF;
      for (int c = 0; c < 12; c++) begin
         cache_resp_hit  = 1'($urandom);
         cache_resp_data = rand_data();
         cycle();
      end
      req_valid = '0;
      repeat (5) cycle();

      // Single read by PE2.
      req_addr[2]     = 33'h1_0000_0040;
      cache_resp_hit  = 1'b1;
      cache_resp_data = DW'(8'hA5);
      req_valid       = 4'b0100;
      cycle();
      req_valid = '0;
      repeat (5) cycle();

      // Write hit by PE1: no data returned.
      req_addr[1]     = 33'h0_0000_1000;
      cache_resp_data = DW'(8'hFF);
      req_valid       = 4'b0010;
      cycle();
      req_valid = '0;
      repeat (5) cycle();

      // Read miss by PE3.
      req_addr[3]    = 33'h1_0000_2000;
      cache_resp_hit = 1'b0;
      req_valid      = 4'b1000;
      cycle();
      req_valid = '0;
      repeat (5) cycle();

      // Stall with four requests in flight.
      rand_reqs();
      cache_resp_hit = 1'b1;
      req_valid      = 4'hF;
      repeat (4) cycle();
      cache_stall = 1'b1;
      repeat (5) cycle();
      cache_stall = 1'b0;
      repeat (3) cycle();
      req_valid = '0;
      repeat (6) cycle();

      // Asynchronous reset two cycles after a grant.
      req_valid = 4'b0100;
      cycle();
      req_valid = 4'hF;
      repeat (2) cycle();
      rst = 1'b1;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) cycle();

      // Randomized traffic with random stalls.
      for (int c = 0; c < 400; c++) begin
         rand_reqs();
         req_valid       = NP'($urandom);
         cache_stall     = ($urandom % 5) == 0;
         cache_resp_hit  = 1'($urandom);
         cache_resp_data = rand_data();
         cycle();
      end
      cache_stall = 1'b0;
      req_valid   = '0;
      repeat (6) cycle();

`ifdef CACHE_ARB_PERF_EN
      chk("perf_grants", DW'(perf_grants), DW'(m_grants));
      chk("perf_stall_cycles", DW'(perf_stall_cycles), DW'(m_stalls));
      chk("perf_misses", DW'(perf_misses), DW'(m_misses));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single PE-side cache access pipeline (address decode, tag compare, data select) among NUM_PE processing-element requesters.
- Grants one request per cycle using round-robin priority.
- Tracks the in-flight requester ID through the fixed-latency cache pipeline and steers the returned read data and hit flag to the owning PE.
- Freezes issue and tracking whenever the cache signals a stall (miss refill in progress).

Parameters:
- NUM_PE, 4, number of requesters; power of 2, range 2..16.
- ID_WIDTH, 2, log2(NUM_PE).
- ADDR_WIDTH, 33, request address; bit 32 is Rd_Wr (1 = read, 0 = write).
- DATA_WIDTH, 512, data word width (matches `DATA_WIDTH).
- PIPE_DEPTH, 3, cache pipeline latency in cycles from issue to response.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PE  per-PE request valid.
- req_addr  in  NUM_PE x ADDR_WIDTH  per-PE address, including the Rd_Wr bit.
- req_wdata  in  NUM_PE x DATA_WIDTH  per-PE write data.
- req_ready  out  NUM_PE  one-hot grant; the request is accepted when valid && ready.
- cache_valid  out  1  issue strobe to the cache pipeline.
- cache_addr  out  ADDR_WIDTH  issued address.
- cache_wdata  out  DATA_WIDTH  issued write data.
- cache_stall  in  1  cache busy; the cache pipeline holds its contents.
- cache_resp_hit  in  1  HIT of the stage-3 request.
- cache_resp_data  in  DATA_WIDTH  Data_pe_out of stage 3.
- resp_valid  out  NUM_PE  one-hot response strobe.
- resp_hit  out  1  1 = completed; 0 = miss, PE must retry.
- resp_data  out  DATA_WIDTH  read data; 0 for writes and misses.

Behaviour:
- Reset: all outputs 0; rr_ptr = 0; tag pipeline valid bits cleared; FSM = ARB.

FSM states:
- ARB
  - If cache_stall = 0 and any req_valid is set, grant the first requester at or after rr_ptr (wrapping modulo NUM_PE).
  - Assert that requester's req_ready combinationally in the same cycle; register cache_valid/addr/wdata for the next cycle.
  - rr_ptr <= granted + 1, mod NUM_PE.
  - If cache_stall = 1, go to STALL.
- STALL
  - req_ready = 0 for all requesters.
  - cache_valid, cache_addr and cache_wdata hold their current values.
  - Tag pipeline and rr_ptr are frozen.
  - Return to ARB on the first cycle with cache_stall = 0; issue resumes in that same cycle.

Issue and tracking:
- At most one grant per cycle. No grant when no request is valid: cache_valid = 0 and rr_ptr is unchanged.
- Tag pipeline: PIPE_DEPTH entries of {valid, id, rd_wr}. It shifts every non-stalled cycle. The entry entering stage 0 is the registered issue.
- Response, in the cycle the final entry is valid and cache_stall = 0:
  - resp_valid[id] = 1.
  - resp_hit = cache_resp_hit.
  - resp_data = cache_resp_data when rd_wr && hit, else 0.
- Response outputs are registered: one cycle after stage-3 data is presented. Total latency from grant to resp_valid is PIPE_DEPTH + 1 cycles.
- A requester may hold req_valid through back-to-back grants. Round-robin moves the grant to other requesters whenever they are pending.

Boundary conditions:
- Stall asserted in the same cycle as a pending grant: no grant is issued.
- Stall during a response cycle: resp_valid is suppressed until the stall is released, and is then emitted exactly once.
- rr_ptr wraps from NUM_PE-1 to 0.
- Asynchronous reset mid-operation drops all in-flight tags without any response. PEs must reissue their requests.

Optional Feature:
- Macro: CACHE_ARB_PERF_EN.
- When defined, adds three outputs:
  - perf_grants (32 bits): count of accepted requests.
  - perf_stall_cycles (32 bits): count of cycles with cache_stall = 1.
  - perf_misses (32 bits): count of responses with resp_hit = 0.
- Counters saturate at 0xFFFFFFFF and clear on rst.
- When not defined: no counters and no extra ports; the block behaves identically otherwise.

Test Plan:
- Single read:
  - Stimulus: PE2 requests address 0x1_0000_0040 (read); cache_resp_hit = 1, data 0xA5 at stage 3.
  - Required: req_ready[2] in cycle 0; resp_valid = 4'b0100, resp_hit = 1, resp_data = 0xA5 in cycle 4.
- All four PEs valid continuously from reset:
  - Required: grant order 0,1,2,3,0,1…, one grant per cycle; responses arrive in the same order, each 4 cycles after its grant.
- Write hit:
  - Stimulus: PE1 writes (bit32 = 0) with cache_resp_data = 0xFF.
  - Required: resp_valid[1] = 1, resp_hit = 1, resp_data = 0.
- Miss:
  - Stimulus: PE3 read with cache_resp_hit = 0.
  - Required: resp_valid[3], resp_hit = 0, resp_data = 0.
- Stall mid-stream:
  - Stimulus: 4 requests in flight; cache_stall = 1 for 5 cycles.
  - Required: no req_ready, no resp_valid, cache outputs stable during the stall; afterwards every remaining response appears exactly once and grants resume in the first cycle after the stall.
- Reset mid-operation:
  - Stimulus: assert rst 2 cycles after a grant.
  - Required: all outputs 0 immediately; no stale response after rst is released; the first post-reset grant goes to PE0 if it is valid.
